// File: rtl/adc_rec_pkg.sv
// Shared definitions for the ADC recording path: sample type and default
// averaging / buffering geometry used by capture, buffer and memory writer.
package adc_rec_pkg;

  localparam int SAMPLE_W       = 12;
  localparam int AVG_LOG2_DEF   = 2;
  localparam int DEPTH_LOG2_DEF = 4;

  typedef logic [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO on a register array with occupancy output.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH      = 12,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      push_data_i,
  output logic                  push_ok_o,
  input  logic                  pop_i,
  output logic [WIDTH-1:0]      head_o,
  output logic                  valid_o,
  output logic [DEPTH_LOG2:0]   level_o
);

  localparam int LVL_W = DEPTH_LOG2 + 1;
  localparam logic [LVL_W-1:0]      LVL_FULL = LVL_W'(1 << DEPTH_LOG2);
  localparam logic [LVL_W-1:0]      LVL_ONE  = LVL_W'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic [WIDTH-1:0]      mem_q [1 << DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic                  pop_s, push_s, full_s, nonempty_s;

  // Pointer and occupancy next-state; pops while empty are ignored.
  always_comb begin
    nonempty_s = (level_q != {LVL_W{1'b0}});
    full_s     = (level_q == LVL_FULL);
    pop_s      = pop_i && nonempty_s;
    push_s     = push_i && (!full_s || pop_s);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (push_s && !pop_s) begin
      level_d = level_q + LVL_ONE;
    end else if (pop_s && !push_s) begin
      level_d = level_q - LVL_ONE;
    end else begin
      level_d = level_q;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {DEPTH_LOG2{1'b0}};
      rd_ptr_q <= {DEPTH_LOG2{1'b0}};
      level_q  <= {LVL_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents are only observable while valid, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign push_ok_o = push_s;
  assign valid_o   = nonempty_s;
  assign level_o   = level_q;
  assign head_o    = nonempty_s ? mem_q[rd_ptr_q] : {WIDTH{1'b0}};

endmodule

// File: rtl/adc_sample_buffer.sv
// Block-averages accepted ADC samples and queues the averages for the memory
// writer; averages that find the queue full are dropped and flagged.
module adc_sample_buffer
  import adc_rec_pkg::*;
#(
  parameter int AVG_LOG2   = AVG_LOG2_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rec_en,
  input  sample_t             sample_in,
  input  logic                sample_stb,
  output sample_t             out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DEPTH_LOG2:0] level,
  output logic                overflow,
  input  logic                ovf_clr
);

  localparam int ACC_W = SAMPLE_W + AVG_LOG2;
  // Keep the counter at least one bit so pass-through mode needs no special case.
  localparam int IDX_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'((1 << AVG_LOG2) - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  logic [ACC_W-1:0] acc_q, acc_d, sum_s;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             overflow_q, overflow_d;
  logic             push_s, push_ok_s, drop_s;
  sample_t          avg_s;

  // Accumulate a block; on its last sample emit the truncated mean.
  always_comb begin
    sum_s  = acc_q + ACC_W'(sample_in);
    avg_s  = sum_s[ACC_W-1:AVG_LOG2];
    acc_d  = acc_q;
    idx_d  = idx_q;
    push_s = 1'b0;
    if (!rec_en) begin
      acc_d = {ACC_W{1'b0}};
      idx_d = {IDX_W{1'b0}};
    end else if (sample_stb) begin
      if (idx_q == IDX_LAST) begin
        push_s = 1'b1;
        acc_d  = {ACC_W{1'b0}};
        idx_d  = {IDX_W{1'b0}};
      end else begin
        acc_d = sum_s;
        idx_d = idx_q + IDX_ONE;
      end
    end else begin
      acc_d = acc_q;
      idx_d = idx_q;
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_comb begin
    drop_s = push_s && !push_ok_s;
    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Accumulator, block counter and overflow registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q      <= {ACC_W{1'b0}};
      idx_q      <= {IDX_W{1'b0}};
      overflow_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      overflow_q <= overflow_d;
    end
  end

  sync_fifo #(
    .WIDTH      (SAMPLE_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push_s),
    .push_data_i (avg_s),
    .push_ok_o   (push_ok_s),
    .pop_i       (out_ready),
    .head_o      (out_data),
    .valid_o     (out_valid),
    .level_o     (level)
  );

  assign overflow = overflow_q;

endmodule

// File: tb/tb_adc_sample_buffer.sv
// Bench for adc_sample_buffer: three instances (AVG_LOG2 = 0, 2, 4) share one
// stimulus stream and are compared every cycle against a queue-based model.
module tb_adc_sample_buffer;
  import adc_rec_pkg::*;

  logic       clk = 1'b0;
  logic       rst, rec_en, sample_stb, out_ready, ovf_clr;
  sample_t    sample_in;
  sample_t    od  [3];
  logic       vld [3];
  logic       ovf [3];
  logic [4:0] lvl [3];

  int unsigned mq [3][$];
  int unsigned msum [3];
  int          mcnt [3];
  bit          movf [3];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    adc_sample_buffer #(.AVG_LOG2(2 * g), .DEPTH_LOG2(4)) u_dut (
      .clk(clk), .rst(rst), .rec_en(rec_en), .sample_in(sample_in),
      .sample_stb(sample_stb), .out_data(od[g]), .out_valid(vld[g]),
      .out_ready(out_ready), .level(lvl[g]), .overflow(ovf[g]), .ovf_clr(ovf_clr)
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mq[k].delete();
      msum[k] = 0;
      mcnt[k] = 0;
      movf[k] = 1'b0;
    end
  endtask

  // Applies one clock edge worth of behaviour using the current inputs.
  task automatic model_step();
    int          sz;
    bit          pop, push;
    int unsigned v;
    for (int k = 0; k < 3; k++) begin
      sz   = mq[k].size();
      pop  = (sz > 0) && out_ready;
      push = 1'b0;
      v    = 0;
      if (!rec_en) begin
        msum[k] = 0;
        mcnt[k] = 0;
      end else if (sample_stb) begin
        msum[k] += sample_in;
        mcnt[k]++;
        if (mcnt[k] == (1 << (2 * k))) begin
          push    = 1'b1;
          v       = msum[k] / (1 << (2 * k));
          msum[k] = 0;
          mcnt[k] = 0;
        end
      end
      if (pop) void'(mq[k].pop_front());
      if (push) begin
        if (sz < 16 || pop) mq[k].push_back(v);
        else movf[k] = 1'b1;
      end else if (ovf_clr) begin
        movf[k] = 1'b0;
      end
      if (push && (sz >= 16) && !pop) movf[k] = 1'b1;
      else if (ovf_clr) movf[k] = 1'b0;
    end
  endtask

  task automatic compare_all();
    int sz;
    for (int k = 0; k < 3; k++) begin
      sz = mq[k].size();
      chk($sformatf("valid[%0d]", k), vld[k], (sz > 0) ? 1 : 0);
      chk($sformatf("level[%0d]", k), lvl[k], sz);
      chk($sformatf("data[%0d]", k), od[k], (sz > 0) ? mq[k][0] : 0);
      chk($sformatf("ovf[%0d]", k), ovf[k], movf[k]);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic strobe(input int s);
    sample_stb = 1'b1;
    sample_in  = 12'(s);
    cycle();
    sample_stb = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    compare_all();
  endtask

  initial begin
    rst = 1'b1; rec_en = 1'b0; sample_stb = 1'b0; sample_in = 12'd0;
    out_ready = 1'b0; ovf_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_valid", vld[k], 0);
      chk("rst_level", lvl[k], 0);
      chk("rst_data", od[k], 0);
      chk("rst_ovf", ovf[k], 0);
    end
    rst = 1'b0;
    rec_en = 1'b1;

    // Averaging of four samples.
    strobe(100); strobe(101); strobe(102); strobe(104);
    chk("avg4_valid", vld[1], 1);
    chk("avg4_data", od[1], 101);
    chk("avg4_level", lvl[1], 1);

    // Sixteen full-scale samples average without wrap.
    do_reset();
    for (int i = 0; i < 16; i++) strobe(12'hFFF);
    chk("max16_data", od[2], 12'hFFF);
    chk("max16_level", lvl[2], 1);

    // Partial block discarded by a rec_en drop.
    do_reset();
    strobe(500); strobe(500);
    rec_en = 1'b0; cycle(); rec_en = 1'b1;
    for (int i = 0; i < 4; i++) strobe(8);
    chk("discard_level", lvl[1], 1);
    chk("discard_data", od[1], 8);

    // Overflow in pass-through, set beats clear, then drain.
    do_reset();
    for (int i = 1; i <= 17; i++) strobe(i);
    chk("ovf_level", lvl[0], 16);
    chk("ovf_set", ovf[0], 1);
    ovf_clr = 1'b1; strobe(18); ovf_clr = 1'b0;
    chk("ovf_set_wins", ovf[0], 1);
    out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      chk("drain_data", od[0], i);
      cycle();
    end
    chk("drain_empty", lvl[0], 0);
    out_ready = 1'b0;
    ovf_clr = 1'b1; cycle(); ovf_clr = 1'b0;
    chk("ovf_cleared", ovf[0], 0);

    // Push and pop together while full.
    do_reset();
    for (int i = 1; i <= 16; i++) strobe(i);
    out_ready = 1'b1;
    strobe(99);
    chk("full_pp_level", lvl[0], 16);
    chk("full_pp_ovf", ovf[0], 0);
    for (int i = 0; i < 15; i++) cycle();
    chk("full_pp_last", od[0], 99);
    chk("full_pp_lvl1", lvl[0], 1);
    out_ready = 1'b0;

    // Asynchronous reset between edges, mid-block with five entries queued.
    do_reset();
    for (int i = 0; i < 5; i++) strobe(1000);
    chk("pre_rst_level", lvl[0], 5);
    #3;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("arst_valid", vld[k], 0);
      chk("arst_level", lvl[k], 0);
      chk("arst_data", od[k], 0);
      chk("arst_ovf", ovf[k], 0);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) strobe(40);
    chk("post_rst_avg", od[1], 40);
    chk("post_rst_level", lvl[1], 1);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rec_en     = ($urandom_range(0, 9) != 0);
      sample_stb = ($urandom_range(0, 2) != 0);
      sample_in  = 12'($urandom_range(0, 4095));
      out_ready  = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      ovf_clr    = ($urandom_range(0, 15) == 0);
      cycle();
    end
    sample_stb = 1'b0;
    ovf_clr    = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
